// File: rtl/uart_cmd_decoder_if.sv
// Command-decoder bus: UART RX bytes and busy in; counter load, control strobes and ack out.
interface uart_cmd_decoder_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       cnt_shift;
    logic [7:0] cnt_byte;
    logic       start;
    logic       clear;
    logic       load_done;
    logic       err;
    logic [7:0] ack_data;
    logic       ack_valid;

    modport master (
        output rx_data, rx_valid, busy,
        input  cnt_shift, cnt_byte, start, clear, load_done, err, ack_data, ack_valid
    );

    modport slave (
        input  rx_data, rx_valid, busy,
        output cnt_shift, cnt_byte, start, clear, load_done, err, ack_data, ack_valid
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Decodes single-character host commands into counter-load bytes, start/clear strobes
// and a one-byte acknowledge; a load command collects 4 payload bytes with an idle timeout.
module uart_cmd_decoder #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000,
    parameter logic [7:0]  CMD_LOAD       = 8'h4E,
    parameter logic [7:0]  CMD_START      = 8'h53,
    parameter logic [7:0]  CMD_CLEAR      = 8'h43
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_cmd_decoder_if.slave    bus_if
);

    localparam logic [7:0] ACK_OK  = 8'h4B;
    localparam logic [7:0] ACK_REJ = 8'h3F;
    localparam logic [7:0] ACK_TMO = 8'h21;

    typedef enum logic {IDLE, LOAD} state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [23:0] timer_q, timer_d;
    logic        cnt_shift_q, cnt_shift_d;
    logic [7:0]  cnt_byte_q, cnt_byte_d;
    logic        start_q, start_d;
    logic        clear_q, clear_d;
    logic        load_done_q, load_done_d;
    logic        err_q, err_d;
    logic [7:0]  ack_data_q, ack_data_d;
    logic        ack_valid_q, ack_valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            timer_q     <= 24'd0;
            cnt_shift_q <= 1'b0;
            cnt_byte_q  <= 8'd0;
            start_q     <= 1'b0;
            clear_q     <= 1'b0;
            load_done_q <= 1'b0;
            err_q       <= 1'b0;
            ack_data_q  <= 8'd0;
            ack_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            cnt_shift_q <= cnt_shift_d;
            cnt_byte_q  <= cnt_byte_d;
            start_q     <= start_d;
            clear_q     <= clear_d;
            load_done_q <= load_done_d;
            err_q       <= err_d;
            ack_data_q  <= ack_data_d;
            ack_valid_q <= ack_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        cnt_shift_d = 1'b0;
        cnt_byte_d  = cnt_byte_q;
        start_d     = 1'b0;
        clear_d     = 1'b0;
        load_done_d = 1'b0;
        err_d       = 1'b0;
        ack_data_d  = ack_data_q;
        ack_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                idx_d   = 2'd0;
                timer_d = 24'd0;
                if (bus_if.rx_valid) begin
                    if (bus_if.rx_data == CMD_CLEAR) begin
                        clear_d     = 1'b1;
                        ack_data_d  = ACK_OK;
                        ack_valid_d = 1'b1;
                    end else if (bus_if.rx_data == CMD_LOAD && !bus_if.busy) begin
                        state_d = LOAD;
                    end else if (bus_if.rx_data == CMD_START && !bus_if.busy) begin
                        start_d     = 1'b1;
                        ack_data_d  = ACK_OK;
                        ack_valid_d = 1'b1;
                    end else begin
                        err_d       = 1'b1;
                        ack_data_d  = ACK_REJ;
                        ack_valid_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                // An arriving byte takes priority over an expiring timer.
                if (bus_if.rx_valid) begin
                    cnt_byte_d  = bus_if.rx_data;
                    cnt_shift_d = 1'b1;
                    idx_d       = idx_q + 2'd1;
                    timer_d     = 24'd0;
                    if (idx_q == 2'd3) begin
                        load_done_d = 1'b1;
                        ack_data_d  = ACK_OK;
                        ack_valid_d = 1'b1;
                        state_d     = IDLE;
                    end
                end else if (timer_q == TIMEOUT_CYCLES - 24'd1) begin
                    err_d       = 1'b1;
                    ack_data_d  = ACK_TMO;
                    ack_valid_d = 1'b1;
                    timer_d     = 24'd0;
                    idx_d       = 2'd0;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q + 24'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus_if.cnt_shift = cnt_shift_q;
    assign bus_if.cnt_byte  = cnt_byte_q;
    assign bus_if.start     = start_q;
    assign bus_if.clear     = clear_q;
    assign bus_if.load_done = load_done_q;
    assign bus_if.err       = err_q;
    assign bus_if.ack_data  = ack_data_q;
    assign bus_if.ack_valid = ack_valid_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed plus randomized stimulus for uart_cmd_decoder, checked every cycle against a
// transaction-level model of the command protocol (cycle numbers, not a timer register).
module tb_uart_cmd_decoder;

    localparam int T = 16;

    logic clk;
    logic rst;
    uart_cmd_decoder_if u_if ();

    uart_cmd_decoder #(
        .TIMEOUT_CYCLES (24'd16),
        .CMD_LOAD       (8'h4E),
        .CMD_START      (8'h53),
        .CMD_CLEAR      (8'h43)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int check_cnt = 0;

    // Reference model state
    bit         m_in_load = 0;
    int         m_nbytes  = 0;
    int         m_last    = 0;
    int         cyc       = 0;
    logic       e_shift, e_start, e_clear, e_done, e_err, e_ackv;
    logic [7:0] e_byte = 8'd0;
    logic [7:0] e_ack  = 8'd0;
    logic [31:0] ds_cnt = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s at cyc %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    endtask

    task automatic model(input logic r, input logic v, input logic [7:0] d, input logic b);
        {e_shift, e_start, e_clear, e_done, e_err, e_ackv} = '0;
        if (r) begin
            m_in_load = 0;
            m_nbytes  = 0;
            e_byte    = 8'd0;
            e_ack     = 8'd0;
        end else if (!m_in_load) begin
            if (v) begin
                if (d == "C") begin
                    e_clear = 1; e_ackv = 1; e_ack = "K";
                end else if (d == "N" && !b) begin
                    m_in_load = 1; m_nbytes = 0; m_last = cyc;
                end else if (d == "S" && !b) begin
                    e_start = 1; e_ackv = 1; e_ack = "K";
                end else begin
                    e_err = 1; e_ackv = 1; e_ack = "?";
                end
            end
        end else begin
            if (v) begin
                e_shift = 1; e_byte = d; m_nbytes++; m_last = cyc;
                if (m_nbytes == 4) begin
                    e_done = 1; e_ackv = 1; e_ack = "K"; m_in_load = 0;
                end
            end else if (cyc - m_last == T) begin
                e_err = 1; e_ackv = 1; e_ack = "!"; m_in_load = 0;
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] d, input logic b);
        rst          = r;
        u_if.rx_valid = v;
        u_if.rx_data  = d;
        u_if.busy     = b;
        @(posedge clk);
        model(r, v, d, b);
        #1;
        chk("cnt_shift", {31'd0, u_if.cnt_shift}, {31'd0, e_shift});
        chk("cnt_byte",  {24'd0, u_if.cnt_byte},  {24'd0, e_byte});
        chk("start",     {31'd0, u_if.start},     {31'd0, e_start});
        chk("clear",     {31'd0, u_if.clear},     {31'd0, e_clear});
        chk("load_done", {31'd0, u_if.load_done}, {31'd0, e_done});
        chk("err",       {31'd0, u_if.err},       {31'd0, e_err});
        chk("ack_valid", {31'd0, u_if.ack_valid}, {31'd0, e_ackv});
        chk("ack_data",  {24'd0, u_if.ack_data},  {24'd0, e_ack});
        if (u_if.cnt_shift) ds_cnt = {u_if.cnt_byte, ds_cnt[31:8]};
        if (e_ackv) $display("cyc %0d: ack %02h (start=%0b clear=%0b done=%0b err=%0b)",
                             cyc, e_ack, e_start, e_clear, e_done, e_err);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        logic [7:0] cmds [4];
        cmds[0] = "N"; cmds[1] = "S"; cmds[2] = "C"; cmds[3] = 8'h00;
        rst = 1'b1;
        u_if.rx_valid = 1'b0;
        u_if.rx_data  = 8'h00;
        u_if.busy     = 1'b0;

        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);

        // Load 5000000, back-to-back bytes
        ds_cnt = 32'd0;
        step(1'b0, 1'b1, "N", 1'b0);
        step(1'b0, 1'b1, 8'h40, 1'b0);
        step(1'b0, 1'b1, 8'h4B, 1'b0);
        step(1'b0, 1'b1, 8'h4C, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("ds_count", ds_cnt, 32'd5_000_000);
        idle(2);

        // Start / busy handling
        step(1'b0, 1'b1, "S", 1'b0);
        step(1'b0, 1'b1, "S", 1'b1);
        step(1'b0, 1'b1, "C", 1'b1);
        step(1'b0, 1'b1, 8'h7A, 1'b0);
        step(1'b0, 1'b1, "N", 1'b1);
        idle(1);

        // Timeout after one payload byte, then a command is decoded again
        step(1'b0, 1'b1, "N", 1'b0);
        step(1'b0, 1'b1, 8'h11, 1'b0);
        idle(T + 2);
        step(1'b0, 1'b1, "S", 1'b0);
        idle(1);

        // Byte exactly on the expiry cycle wins
        step(1'b0, 1'b1, "N", 1'b0);
        idle(T - 1);
        step(1'b0, 1'b1, 8'hA1, 1'b0);
        idle(T - 1);
        step(1'b0, 1'b1, 8'hA2, 1'b0);
        step(1'b0, 1'b1, 8'hA3, 1'b0);
        step(1'b0, 1'b1, 8'hA4, 1'b0);
        idle(2);

        // Reset mid-load; following byte is a rejected command
        step(1'b0, 1'b1, "N", 1'b0);
        step(1'b0, 1'b1, 8'h01, 1'b0);
        step(1'b0, 1'b1, 8'h02, 1'b0);
        step(1'b1, 1'b1, 8'h03, 1'b0);
        step(1'b0, 1'b1, 8'h22, 1'b0);
        idle(1);

        // Randomized traffic
        for (int n = 0; n < 2500; n++) begin
            int r;
            logic [7:0] d;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                idle(int'($urandom_range(T - 3, T + 3)));
            end else if (r < 4) begin
                step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
            end else begin
                d = cmds[$urandom_range(0, 3)];
                if (d == 8'h00 || $urandom_range(0, 3) == 0) d = 8'($urandom);
                step(1'b0, 1'($urandom_range(0, 99) < 60), d, 1'($urandom_range(0, 99) < 30));
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
